int_arbiter: RTL

Programmable interrupt controller that merges up to eight peripheral interrupt sources into the single `INT` input of the MIPS core. Typical sources are counter0/1/2 outputs, button pulses and GPIO events. The block lives on the MIO bus as a memory-mapped slave and provides per-source masking, edge/level selection and fixed-priority arbitration. The core sees one request at a time through a claim/end-of-interrupt (EOI) handshake; nesting is not supported.

---
 rtl/int_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/int_arbiter.sv
// Memory-mapped interrupt arbiter: synchronizes up to eight sources, tracks pending bits in edge or
// level mode, and presents the lowest-index enabled request to the CPU through a claim/EOI handshake.
module int_arbiter #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             INT,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SERVICE
  } state_t;

  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_MODE  = 2'd2;
  localparam logic [1:0] ADDR_CLAIM = 2'd3;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] mask_reg, mode_reg;
  logic [2:0]       isr_id_reg;
  logic             int_reg, int_next;
  logic             busy_reg, busy_next;

  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] pend_view;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [2:0]       winner;
  logic             claim_rd;
  logic             eoi_wr;
  logic             wr_mask, wr_mode;
  logic [31:0]      claim_data;

  assign wr_mask  = cs & we & (addr == ADDR_MASK);
  assign wr_mode  = cs & we & (addr == ADDR_MODE);
  assign eoi_wr   = cs & we & (addr == ADDR_CLAIM);
  assign w1c      = (cs & we & (addr == ADDR_PEND)) ? wdata[N_SRC-1:0] : '0;
  assign req      = pend_view & mask_reg;
  assign claim_rd = cs & ~we & (addr == ADDR_CLAIM) & (state_reg == IDLE) & (|req);

  // Lowest set index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    winner = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) winner = i[2:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign edge_det[gi]  = s2_reg[gi] & ~s3_reg[gi];
      assign claim_clr[gi] = claim_rd & (winner == 3'(gi));
      // A fresh edge overrides both W1C and claim clears; level bits keep pend_reg at zero.
      assign pend_next[gi] = mode_reg[gi]
                           ? (edge_det[gi] | (pend_reg[gi] & ~w1c[gi] & ~claim_clr[gi]))
                           : 1'b0;
      assign pend_view[gi] = mode_reg[gi] ? pend_reg[gi] : s2_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (claim_rd) state_next = SERVICE;
      SERVICE: if (eoi_wr)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Held low on the claim edge and on the EOI edge, so a still-pending source re-raises one edge after EOI.
    int_next  = (|req) & (state_reg == IDLE) & ~claim_rd;
    busy_next = (state_next == SERVICE);
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_reg  <= IDLE;
      s1_reg     <= '0;
      s2_reg     <= '0;
      s3_reg     <= '0;
      pend_reg   <= '0;
      mask_reg   <= '0;
      mode_reg   <= '1;
      isr_id_reg <= 3'd0;
      int_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      s1_reg    <= irq_src;
      s2_reg    <= s1_reg;
      s3_reg    <= s2_reg;
      pend_reg  <= pend_next;
      int_reg   <= int_next;
      busy_reg  <= busy_next;
      if (wr_mask)  mask_reg   <= wdata[N_SRC-1:0];
      if (wr_mode)  mode_reg   <= wdata[N_SRC-1:0];
      if (claim_rd) isr_id_reg <= winner;
    end
  end

  assign claim_data = ((state_reg == IDLE) && (|req)) ? {1'b1, 28'b0, winner} : 32'h0000_0000;

  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      ADDR_PEND:  rdata[N_SRC-1:0] = pend_view;
      ADDR_MASK:  rdata[N_SRC-1:0] = mask_reg;
      ADDR_MODE:  rdata[N_SRC-1:0] = mode_reg;
      ADDR_CLAIM: rdata = claim_data;
      default:    rdata = 32'h0000_0000;
    endcase
  end

  assign INT  = int_reg;
  assign busy = busy_reg;

  // The in-service id is kept as internal state only; upper write-data bits have no destination.
  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[31:N_SRC], isr_id_reg};

endmodule
